write_back: RTL and testbench



---
 rtl/write_back_pkg.sv | 26 ++
 rtl/write_back_if.sv | 34 +++
 rtl/write_back_register_file.sv | 54 +++++
 rtl/write_back.sv | 91 +++++++++
 tb/tb_write_back.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/write_back_pkg.sv
// write_back_pkg: shared types and constants for the write-back stage.
//   WB_XLEN / WB_NREG : default data/PC width and register count
//   REG_ZERO          : architectural zero register index
//   instructions      : retiring-instruction record handed over by execute
//   wb_state_t        : write-back FSM state encoding
// Optional feature macro used by this slice: WRITE_BACK_INSTRET_EN.
package write_back_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_NREG = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_XLEN-1:0] pc;
        logic [4:0]         rd_addr;
        logic               writes_rd;
    } instructions;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        DONE
    } wb_state_t;

endpackage

// File: rtl/write_back_if.sv
// write_back_if: bundle between execute/decode (master) and write-back (slave).
//   enabled/instr/rd/is_jump/jump_dest : retirement request from execute
//   completed/pc_next                  : stage done pulse and next fetch PC
//   rs1_addr/rs2_addr -> rs1_data/rs2_data : decode register read ports
// Handshake: execute raises enabled for exactly one cycle while write-back
// is idle; write-back answers with a one-cycle completed pulse two cycles
// later. enabled must stay low until completed has been seen.
interface write_back_if
    import write_back_pkg::*;
();

    logic               enabled;
    instructions        instr;
    logic [WB_XLEN-1:0] rd;
    logic               is_jump;
    logic [WB_XLEN-1:0] jump_dest;
    logic               completed;
    logic [WB_XLEN-1:0] pc_next;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [WB_XLEN-1:0] rs1_data;
    logic [WB_XLEN-1:0] rs2_data;

    modport master (
        output enabled, instr, rd, is_jump, jump_dest, rs1_addr, rs2_addr,
        input  completed, pc_next, rs1_data, rs2_data
    );

    modport slave (
        input  enabled, instr, rd, is_jump, jump_dest, rs1_addr, rs2_addr,
        output completed, pc_next, rs1_data, rs2_data
    );

endinterface

// File: rtl/write_back_register_file.sv
// register_file: NREG x XLEN architectural registers.
//   clk, rstn     : clock, async active-high reset (clears every register)
//   we/waddr/wdata: single write port
//   raddr1/raddr2 : asynchronous read addresses
//   rdata1/rdata2 : read data; x0 reads 0, a pending write is forwarded
module register_file
    import write_back_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-through: the value being committed this cycle is visible to
    // decode in the same cycle, so no stall is needed for a back-to-back use.
    always_comb begin
        if (raddr1 == '0)
            rdata1 = '0;
        else if (we && (raddr1 == waddr))
            rdata1 = wdata;
        else
            rdata1 = regs[raddr1];

        if (raddr2 == '0)
            rdata2 = '0;
        else if (we && (raddr2 == waddr))
            rdata2 = wdata;
        else
            rdata2 = regs[raddr2];
    end

endmodule

// File: rtl/write_back.sv
// write_back: final pipeline stage. Latches the retiring instruction from
// execute, commits its result to the register file it owns, and computes
// the next fetch PC (word address, wraps silently).
//   clk, rstn : clock, async active-high reset
//   bus       : write_back_if.slave (execute request, decode read ports)
//   state_dbg : current FSM state
//   instret   : retired-instruction count (only with WRITE_BACK_INSTRET_EN)
module write_back
    import write_back_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int NREG = WB_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rstn,
    write_back_if.slave     bus,
    output wb_state_t       state_dbg
`ifdef WRITE_BACK_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    wb_state_t       state;
    instructions     instr_q;
    logic [XLEN-1:0] rd_q;
    logic [XLEN-1:0] jump_dest_q;
    logic            is_jump_q;
    logic [XLEN-1:0] pc_next_q;
    logic            reg_we;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state       <= IDLE;
            instr_q     <= '0;
            rd_q        <= '0;
            jump_dest_q <= '0;
            is_jump_q   <= 1'b0;
            pc_next_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enabled) begin
                        instr_q     <= bus.instr;
                        rd_q        <= bus.rd;
                        jump_dest_q <= bus.jump_dest;
                        is_jump_q   <= bus.is_jump;
                        state       <= COMMIT;
                    end
                end
                COMMIT: begin
                    pc_next_q <= is_jump_q ? jump_dest_q : instr_q.pc + 1'b1;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // x0 writes are filtered here so the bypass path never forwards them.
    assign reg_we = (state == COMMIT) && instr_q.writes_rd && (instr_q.rd_addr != REG_ZERO);

    register_file #(.XLEN(XLEN), .NREG(NREG)) u_regs (
        .clk    (clk),
        .rstn   (rstn),
        .we     (reg_we),
        .waddr  (AW'(instr_q.rd_addr)),
        .wdata  (rd_q),
        .raddr1 (AW'(bus.rs1_addr)),
        .raddr2 (AW'(bus.rs2_addr)),
        .rdata1 (bus.rs1_data),
        .rdata2 (bus.rs2_data)
    );

    // completed is masked while enabled is high, matching execute's handshake.
    assign bus.completed = (state == DONE) && !bus.enabled;
    assign bus.pc_next   = pc_next_q;
    assign state_dbg     = state;

`ifdef WRITE_BACK_INSTRET_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)
            instret <= '0;
        else if (state == COMMIT)
            instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;
    import write_back_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    write_back_if bus ();
    wb_state_t state_dbg;
`ifdef WRITE_BACK_INSTRET_EN
    logic [63:0] instret;
`endif

    write_back dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef WRITE_BACK_INSTRET_EN
        ,
        .instret   (instret)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, next PC, retire count and
    // the one retirement in flight (enable cycle plus its payload).
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [63:0] m_instret;
    bit          pend_valid;
    int          pend_cyc;
    logic [31:0] p_pc, p_rd, p_dest;
    logic [4:0]  p_addr;
    logic        p_wr, p_jump;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc       = '0;
        m_instret  = '0;
        pend_valid = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit in_commit);
        if (a == 5'd0) return 32'd0;
        if (in_commit && p_wr && p_addr != 5'd0 && a == p_addr) return p_rd;
        return m_regs[a];
    endfunction

    // Single compare process: every falling edge.
    always @(negedge clk) begin
        bit exp_comp;
        bit in_commit;
        exp_comp  = 1'b0;
        in_commit = pend_valid && (cyc == pend_cyc + 1);
        if (pend_valid && (cyc == pend_cyc + 2)) begin
            if (p_wr && p_addr != 5'd0) m_regs[p_addr] = p_rd;
            m_pc       = p_jump ? p_dest : p_pc + 32'd1;
            m_instret  = m_instret + 64'd1;
            pend_valid = 1'b0;
            exp_comp   = 1'b1;
        end
        chk("completed", {63'd0, bus.completed}, {63'd0, exp_comp});
        chk("pc_next", {32'd0, bus.pc_next}, {32'd0, m_pc});
        chk("rs1_data", {32'd0, bus.rs1_data}, {32'd0, model_read(bus.rs1_addr, in_commit)});
        chk("rs2_data", {32'd0, bus.rs2_data}, {32'd0, model_read(bus.rs2_addr, in_commit)});
        chk("protocol", {63'd0, bus.enabled && (state_dbg != IDLE)}, 64'd0);
`ifdef WRITE_BACK_INSTRET_EN
        chk("instret", instret, m_instret);
`endif
    end

    // ---------------- driver tasks ----------------
    // Raises enabled for one cycle; returns shortly after the edge that
    // starts the COMMIT cycle.
    task automatic start_op(input logic [31:0] pc, input logic [4:0] addr, input logic wr,
                            input logic [31:0] rd, input logic jump, input logic [31:0] dest);
        @(posedge clk); #1;
        bus.enabled         = 1'b1;
        bus.instr.pc        = pc;
        bus.instr.rd_addr   = addr;
        bus.instr.writes_rd = wr;
        bus.rd              = rd;
        bus.is_jump         = jump;
        bus.jump_dest       = dest;
        p_pc = pc; p_addr = addr; p_wr = wr; p_rd = rd; p_jump = jump; p_dest = dest;
        pend_cyc   = cyc;
        pend_valid = 1'b1;
        @(posedge clk); #1;
        bus.enabled = 1'b0;
    endtask

    // Walks through DONE (checking the pulse and PC) back to IDLE.
    task automatic finish_op(input string name, input logic [31:0] exp_pc);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_completed"}, {63'd0, bus.completed}, 64'd1);
        chk({name, "_pc_next"}, {32'd0, bus.pc_next}, {32'd0, exp_pc});
        @(posedge clk); #1;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] ea, input logic [31:0] eb);
        @(posedge clk); #1;
        bus.rs1_addr = a;
        bus.rs2_addr = b;
        @(negedge clk);
        chk({name, "_rs1"}, {32'd0, bus.rs1_data}, {32'd0, ea});
        chk({name, "_rs2"}, {32'd0, bus.rs2_data}, {32'd0, eb});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        bus.enabled   = 1'b0;
        bus.instr     = '0;
        bus.rd        = '0;
        bus.is_jump   = 1'b0;
        bus.jump_dest = '0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;

        // Reset state: all registers zero, PC zero, no completion.
        for (int i = 0; i < 32; i++) begin
            read_chk("reset_regs", 5'(i), 5'(31 - i), 32'd0, 32'd0);
        end
        chk("reset_pc_next", {32'd0, bus.pc_next}, 64'd0);
        chk("reset_completed", {63'd0, bus.completed}, 64'd0);

        // Plain write with sequential PC.
        start_op(32'h10, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        @(negedge clk);
        chk("t1_no_early_completed", {63'd0, bus.completed}, 64'd0);
        finish_op("t1", 32'h11);
        read_chk("t1_reg5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Write to x0 is dropped and never forwarded.
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd5;
        start_op(32'h11, 5'd0, 1'b1, 32'h1234, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_x0_commit", {32'd0, bus.rs1_data}, 64'd0);
        finish_op("t2", 32'h12);
        read_chk("t2_x0_after", 5'd0, 5'd5, 32'd0, 32'hDEADBEEF);

        // Taken jump.
        start_op(32'h20, 5'd6, 1'b1, 32'h0000_0066, 1'b1, 32'h40);
        finish_op("t3", 32'h40);

        // PC wrap at 2^32.
        start_op(32'hFFFF_FFFF, 5'd3, 1'b0, 32'h3333_3333, 1'b0, 32'h0);
        finish_op("t4", 32'h0);
        read_chk("t4_no_write", 5'd3, 5'd6, 32'd0, 32'h66);

        // Both ports bypass the same pending write.
        bus.rs1_addr = 5'd7;
        bus.rs2_addr = 5'd7;
        start_op(32'h30, 5'd7, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
        @(negedge clk);
        chk("t5_bypass_rs1", {32'd0, bus.rs1_data}, 64'hA5A5A5A5);
        chk("t5_bypass_rs2", {32'd0, bus.rs2_data}, 64'hA5A5A5A5);
        finish_op("t5", 32'h31);

        // Reset during COMMIT: write discarded, back to IDLE, no completion.
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd7;
        start_op(32'h50, 5'd9, 1'b1, 32'h9999_9999, 1'b1, 32'h80);
        #1 rstn = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("t6_state_idle", {62'd0, state_dbg}, {62'd0, IDLE});
        chk("t6_pc_next", {32'd0, bus.pc_next}, 64'd0);
        read_chk("t6_regs", 5'd9, 5'd7, 32'd0, 32'd0);
`ifdef WRITE_BACK_INSTRET_EN
        chk("t6_instret_reset", instret, 64'd0);
`endif

        // Three retirements after reset.
        start_op(32'h100, 5'd1, 1'b1, 32'h1, 1'b0, 32'h0);
        finish_op("t7a", 32'h101);
        start_op(32'h101, 5'd0, 1'b1, 32'h2, 1'b0, 32'h0);
        finish_op("t7b", 32'h102);
        start_op(32'h102, 5'd2, 1'b0, 32'h3, 1'b1, 32'h200);
        finish_op("t7c", 32'h200);
        read_chk("t7_regs", 5'd1, 5'd2, 32'h1, 32'h0);
`ifdef WRITE_BACK_INSTRET_EN
        chk("t7_instret", instret, 64'd3);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
